// File: rtl/tone_detect_pkg.sv
// Shared definitions for the tone detector: note codes, nominal period table
// and FSM state encoding. The same table backs the beep tone generator.
package tone_detect_pkg;

  localparam logic [7:0] NOTE_SILENT = 8'd0;
  localparam int         NOTE_COUNT  = 13;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  // Half-period divider values of the generator for notes C (1) .. C' (13).
  function automatic logic [16:0] note_n(input int k);
    logic [16:0] n;
    case (k)
      1:       n = 17'd14931;
      2:       n = 17'd14093;
      3:       n = 17'd13302;
      4:       n = 17'd12555;
      5:       n = 17'd11850;
      6:       n = 17'd11185;
      7:       n = 17'd10558;
      8:       n = 17'd9965;
      9:       n = 17'd9406;
      10:      n = 17'd8878;
      11:      n = 17'd8380;
      12:      n = 17'd7909;
      13:      n = 17'd7465;
      default: n = 17'd0;
    endcase
    return n;
  endfunction

  // Full square-wave period in clk_125mhz cycles; the generator toggles at 62.5 MHz.
  function automatic logic [16:0] note_p(input int k);
    return (note_n(k) << 2) + 17'd2;
  endfunction

endpackage

// File: rtl/tone_detect_match.sv
// Combinational period-to-note decoder: 13 parallel tolerance comparators,
// lowest matching note code wins, no match yields silence.
module tone_match
  import tone_detect_pkg::*;
#(
  parameter int TOL_SHIFT = 6
) (
  input  logic [16:0] period_val,
  output logic [7:0]  candidate
);

  // Scan from the highest code down so the lowest matching code is the final assignment.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a path that
    // skips the assignment infers a latch.
    candidate = NOTE_SILENT;
    for (int k = NOTE_COUNT; k >= 1; k--) begin
      logic [16:0] pk;
      logic [16:0] diff;
      pk   = note_p(k);
      diff = (period_val > pk) ? (period_val - pk) : (pk - period_val);
      if (diff <= (pk >> TOL_SHIFT)) candidate = 8'(k);
    end
  end

endmodule

// File: rtl/tone_detect.sv
// Square-wave period meter and note decoder. Synchronises tone_in, times the
// interval between rising edges, and accepts a note only after STABLE_CNT
// consecutive identical candidates. Silence is declared after TIMEOUT idle cycles.
module tone_detect
  import tone_detect_pkg::*;
#(
  parameter int TOL_SHIFT  = 6,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 131071
) (
  input  logic        clk_125mhz,
  input  logic        reset,
  input  logic        tone_in,
  input  logic        clr_chg,
  output logic [7:0]  note,
  output logic [16:0] period,
  output logic        locked,
  output logic        note_chg
);

  localparam logic [3:0]  STABLE = 4'(STABLE_CNT);
  localparam logic [16:0] TMO    = 17'(TIMEOUT);

  logic        s1, s2, s3;
  logic        rise, at_timeout;
  logic [16:0] cnt, cnt_n;
  state_t      state, state_n;
  logic [3:0]  streak, streak_n;
  logic [7:0]  last_cand, last_n;
  logic [7:0]  cand;
  logic [7:0]  note_n;
  logic [16:0] period_n;
  logic        chg_n;

  assign rise       = s2 & ~s3;
  assign at_timeout = (cnt == TMO);

  tone_match #(.TOL_SHIFT(TOL_SHIFT)) u_match (
    .period_val (cnt),
    .candidate  (cand)
  );

  // Two-flop synchroniser plus a delay flop for rising-edge detection.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Next-state logic: period counter, edge capture, streak filter and silence timeout.
  always_comb begin
    state_n  = state;
    note_n   = note;
    period_n = period;
    streak_n = streak;
    last_n   = last_cand;
    cnt_n    = rise ? 17'd1 : (at_timeout ? cnt : cnt + 17'd1);
    case (state)
      ST_SILENT: begin
        // The first edge only starts timing.
        if (rise) state_n = ST_ARMED;
      end
      ST_ARMED, ST_TRACK: begin
        if (rise) begin
          // An edge coinciding with the timeout still counts; TIMEOUT decodes to silence.
          state_n  = ST_TRACK;
          period_n = cnt;
          last_n   = cand;
          if (cand == last_cand) streak_n = (streak == STABLE) ? streak : streak + 4'd1;
          else                   streak_n = 4'd1;
          if (streak_n == STABLE) note_n = cand;
        end else if (at_timeout) begin
          state_n  = ST_SILENT;
          note_n   = NOTE_SILENT;
          streak_n = 4'd0;
          last_n   = NOTE_SILENT;
        end
      end
      default: state_n = ST_SILENT;
    endcase
    // The CPU clear wins over a same-cycle change.
    if (clr_chg)              chg_n = 1'b0;
    else if (note_n != note)  chg_n = 1'b1;
    else                      chg_n = note_chg;
  end

  // Measurement and output registers.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      // NOTE: every flop here is reset, so a reset mid-measurement aborts cleanly
      // and the next edge only arms.
      state     <= ST_SILENT;
      cnt       <= 17'd0;
      streak    <= 4'd0;
      last_cand <= NOTE_SILENT;
      note      <= NOTE_SILENT;
      period    <= 17'd0;
      locked    <= 1'b0;
      note_chg  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      streak    <= streak_n;
      last_cand <= last_n;
      note      <= note_n;
      period    <= period_n;
      locked    <= (note_n != NOTE_SILENT);
      note_chg  <= chg_n;
    end
  end

endmodule

// File: tb/tb_tone_detect.sv
// Bench for tone_detect: table-driven decoder vectors plus directed
// multi-cycle sequences (arming, lock, rejection, note switch, timeout, reset).
module tb_tone_detect;
  import tone_detect_pkg::*;

  localparam int P_A   = 35514;
  localparam int P_AS  = 33522;
  localparam int P_C   = 59726;
  localparam int P_BAD = 36579;

  logic        clk_125mhz = 1'b0;
  logic        reset;
  logic        tone_in;
  logic        clr_chg;
  logic [7:0]  note;
  logic [16:0] period;
  logic        locked;
  logic        note_chg;

  logic [16:0] mp;
  logic [7:0]  mcand;

  logic [7:0]  pre_note, snap_note;
  logic [16:0] snap_period;
  logic        snap_locked, snap_chg;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [16:0] p;
    logic [7:0]  exp_note;
  } vec_t;

  vec_t vecs[$];

  always #4 clk_125mhz = ~clk_125mhz;

  tone_detect dut (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .tone_in    (tone_in),
    .clr_chg    (clr_chg),
    .note       (note),
    .period     (period),
    .locked     (locked),
    .note_chg   (note_chg)
  );

  tone_match #(.TOL_SHIFT(6)) u_match_ref (
    .period_val (mp),
    .candidate  (mcand)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_125mhz);
    #1;
  endtask

  // One square-wave period starting with its rising edge; snapshots outputs just
  // before and just after the capture caused by that edge.
  task automatic run_period(input int p, input bit clr);
    int hi, lo;
    hi = p / 2;
    lo = p - hi;
    tone_in = 1'b1;
    wait_cyc(2);
    pre_note = note;
    wait_cyc(1);
    snap_note   = note;
    snap_period = period;
    snap_locked = locked;
    snap_chg    = note_chg;
    wait_cyc(hi - 3);
    tone_in = 1'b0;
    if (clr) begin
      clr_chg = 1'b1;
      wait_cyc(1);
      clr_chg = 1'b0;
      wait_cyc(lo - 1);
    end else begin
      wait_cyc(lo);
    end
  endtask

  initial begin
    reset   = 1'b1;
    tone_in = 1'b0;
    clr_chg = 1'b0;
    mp      = 17'd0;

    // Decoder table: exact nominal periods and tolerance edges.
    vecs.push_back('{17'd59726, 8'd1});
    vecs.push_back('{17'd56374, 8'd2});
    vecs.push_back('{17'd53210, 8'd3});
    vecs.push_back('{17'd50222, 8'd4});
    vecs.push_back('{17'd47402, 8'd5});
    vecs.push_back('{17'd44742, 8'd6});
    vecs.push_back('{17'd42234, 8'd7});
    vecs.push_back('{17'd39862, 8'd8});
    vecs.push_back('{17'd37626, 8'd9});
    vecs.push_back('{17'd35514, 8'd10});
    vecs.push_back('{17'd33522, 8'd11});
    vecs.push_back('{17'd31638, 8'd12});
    vecs.push_back('{17'd29862, 8'd13});
    vecs.push_back('{17'd36068, 8'd10});
    vecs.push_back('{17'd36069, 8'd0});
    vecs.push_back('{17'd34960, 8'd10});
    vecs.push_back('{17'd34959, 8'd0});
    vecs.push_back('{17'd60659, 8'd1});
    vecs.push_back('{17'd60660, 8'd0});
    vecs.push_back('{17'd36579, 8'd0});
    vecs.push_back('{17'd0,     8'd0});
    vecs.push_back('{17'd131071, 8'd0});

    foreach (vecs[i]) begin
      mp = vecs[i].p;
      #1;
      check($sformatf("match p=%0d", vecs[i].p), 32'(mcand), 32'(vecs[i].exp_note));
    end

    // 1: reset held while tone_in toggles.
    wait_cyc(2);
    for (int i = 0; i < 3; i++) begin
      tone_in = 1'b1;
      wait_cyc(5);
      tone_in = 1'b0;
      wait_cyc(5);
    end
    check("rst note",     32'(note),     32'd0);
    check("rst period",   32'(period),   32'd0);
    check("rst locked",   32'(locked),   32'd0);
    check("rst note_chg", 32'(note_chg), 32'd0);
    reset = 1'b0;
    wait_cyc(3);

    // 1/2: first rise only arms; lock on A after three captures.
    run_period(P_A, 1'b0);
    check("arm note",   32'(snap_note),   32'd0);
    check("arm period", 32'(snap_period), 32'd0);
    run_period(P_A, 1'b0);
    check("A cap1 period", 32'(snap_period), 32'(P_A));
    check("A cap1 note",   32'(snap_note),   32'd0);
    run_period(P_A, 1'b0);
    check("A cap2 note", 32'(snap_note), 32'd0);
    run_period(P_A, 1'b1);
    check("A cap3 pre",    32'(pre_note),    32'd0);
    check("A cap3 note",   32'(snap_note),   32'd10);
    check("A cap3 locked", 32'(snap_locked), 32'd1);
    check("A cap3 chg",    32'(snap_chg),    32'd1);
    check("A cap3 period", 32'(snap_period), 32'(P_A));
    check("clr chg",       32'(note_chg),    32'd0);
    check("clr note",      32'(note),        32'd10);

    // 3: two out-of-tolerance periods then A again; note must hold.
    run_period(P_BAD, 1'b0);
    check("bad0 note", 32'(snap_note), 32'd10);
    run_period(P_BAD, 1'b0);
    check("bad1 period", 32'(snap_period), 32'(P_BAD));
    check("bad1 note",   32'(snap_note),   32'd10);
    run_period(P_A, 1'b0);
    check("bad2 note", 32'(snap_note), 32'd10);
    run_period(P_A, 1'b0);
    check("reA note",   32'(snap_note),   32'd10);
    check("reA locked", 32'(snap_locked), 32'd1);
    check("reA chg",    32'(snap_chg),    32'd0);

    // 6: reset mid-period while locked, then resume A.
    tone_in = 1'b1;
    wait_cyc(100);
    reset = 1'b1;
    #1;
    check("midrst note",   32'(note),     32'd0);
    check("midrst period", 32'(period),   32'd0);
    check("midrst locked", 32'(locked),   32'd0);
    check("midrst chg",    32'(note_chg), 32'd0);
    wait_cyc(3);
    reset   = 1'b0;
    tone_in = 1'b0;
    wait_cyc(50);
    run_period(P_A, 1'b0);
    check("rearm period", 32'(snap_period), 32'd0);
    run_period(P_A, 1'b0);
    run_period(P_A, 1'b0);
    check("resume cap2 note", 32'(snap_note), 32'd0);
    run_period(P_A, 1'b0);
    check("resume cap3 note",   32'(snap_note),   32'd10);
    check("resume cap3 locked", 32'(snap_locked), 32'd1);

    // 4: switch to A#; note changes exactly at the third A# capture.
    run_period(P_AS, 1'b0);
    run_period(P_AS, 1'b0);
    run_period(P_AS, 1'b1);
    check("As cap2 note", 32'(snap_note), 32'd10);
    run_period(P_C, 1'b0);
    check("As cap3 pre",    32'(pre_note),    32'd10);
    check("As cap3 note",   32'(snap_note),   32'd11);
    check("As cap3 period", 32'(snap_period), 32'(P_AS));
    check("As cap3 chg",    32'(snap_chg),    32'd1);

    // 5: lock on C, then hold low until the timeout declares silence.
    run_period(P_C, 1'b0);
    run_period(P_C, 1'b0);
    check("C cap2 note", 32'(snap_note), 32'd11);
    run_period(P_C, 1'b1);
    check("C cap3 pre",    32'(pre_note),    32'd11);
    check("C cap3 note",   32'(snap_note),   32'd1);
    check("C cap3 period", 32'(snap_period), 32'(P_C));
    wait_cyc(131073 - P_C);
    check("pre-timeout note", 32'(note),     32'd1);
    check("pre-timeout chg",  32'(note_chg), 32'd0);
    wait_cyc(1);
    check("timeout note",   32'(note),     32'd0);
    check("timeout locked", 32'(locked),   32'd0);
    check("timeout chg",    32'(note_chg), 32'd1);
    check("timeout period", 32'(period),   32'(P_C));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
